// File: rtl/ras_ckpt_pkg.sv
// Types and sizing constants shared by the fetch-stage return address stack
// and the branch-recovery unit that stores and replays its checkpoints.
package ras_ckpt_pkg;

  localparam int RAS_DEPTH     = 16;
  localparam int RAS_CNT_WIDTH = 2;
  localparam int RAS_PTR_W     = $clog2(RAS_DEPTH);
  localparam int VADDR_W       = 32;

  typedef logic [VADDR_W-1:0] virt_t;

  typedef struct packed {
    virt_t data;
    logic  valid;
  } ras_t;

  // Everything needed to repair the speculative top in one cycle.
  typedef struct packed {
    logic [RAS_PTR_W-1:0]     ptr;
    logic [RAS_PTR_W:0]       count;
    virt_t                    data;
    logic [RAS_CNT_WIDTH-1:0] rcnt;
  } ras_ckpt_t;

endpackage

// File: rtl/ras_ckpt_if.sv
// Request/response bundle between the fetch predictor (master) and the
// return address stack (slave).
interface ras_ckpt_if;
  import ras_ckpt_pkg::*;

  logic      flush;
  logic      push_req;
  logic      pop_req;
  virt_t     push_data;
  logic      restore_req;
  ras_ckpt_t restore_ckpt;
  ras_t      ras_top;
  ras_ckpt_t ckpt_out;

  modport master (
    output flush, push_req, pop_req, push_data, restore_req, restore_ckpt,
    input  ras_top, ckpt_out
  );

  modport slave (
    input  flush, push_req, pop_req, push_data, restore_req, restore_ckpt,
    output ras_top, ckpt_out
  );

endinterface

// File: rtl/ras_ckpt.sv
// Circular-buffer return address stack with per-entry recursion counters
// and a single-cycle checkpoint restore path.
module ras_ckpt
  import ras_ckpt_pkg::*;
#(
  parameter int DEPTH     = RAS_DEPTH,
  parameter int CNT_WIDTH = RAS_CNT_WIDTH
) (
  input  logic      clk,
  input  logic      reset,
  ras_ckpt_if.slave ras
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef logic [PTR_W-1:0]     ptr_t;
  typedef logic [PTR_W:0]       cnt_t;
  typedef logic [CNT_WIDTH-1:0] rcnt_t;

  typedef struct packed {
    virt_t data;
    rcnt_t rcnt;
  } entry_t;

  localparam cnt_t  FULL     = cnt_t'(DEPTH);
  localparam rcnt_t RCNT_MAX = '1;

  entry_t entry_q [DEPTH];
  entry_t entry_d [DEPTH];
  ptr_t   ptr_q, ptr_d;
  cnt_t   count_q, count_d;
  entry_t top;
  ptr_t   ptr_inc;

  assign top     = entry_q[ptr_q];
  assign ptr_inc = ptr_q + ptr_t'(1);

  // NOTE: every output of this block gets its default before any branch, so
  // no path can leave a variable unassigned and no latch is inferred.
  always_comb begin
    entry_d = entry_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    if (ras.restore_req) begin
      ptr_d   = ras.restore_ckpt.ptr;
      count_d = ras.restore_ckpt.count;
      entry_d[ras.restore_ckpt.ptr] = '{data: ras.restore_ckpt.data,
                                        rcnt: ras.restore_ckpt.rcnt};
    end else if (ras.push_req && ras.pop_req) begin
      // Return then call: the new call site replaces the top in place.
      entry_d[ptr_q] = '{data: ras.push_data, rcnt: '0};
      if (count_q == '0) count_d = cnt_t'(1);
    end else if (ras.push_req) begin
      if (count_q != '0 && ras.push_data == top.data && top.rcnt != RCNT_MAX) begin
        entry_d[ptr_q].rcnt = top.rcnt + rcnt_t'(1);
      end else begin
        ptr_d            = ptr_inc;
        entry_d[ptr_inc] = '{data: ras.push_data, rcnt: '0};
        if (count_q != FULL) count_d = count_q + cnt_t'(1);
      end
    end else if (ras.pop_req && count_q != '0) begin
      if (top.rcnt != '0) begin
        entry_d[ptr_q].rcnt = top.rcnt - rcnt_t'(1);
      end else begin
        ptr_d   = ptr_q - ptr_t'(1);
        count_d = count_q - cnt_t'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset || ras.flush) begin
      ptr_q   <= '0;
      count_q <= '0;
      // NOTE: the entry array is cleared on reset because the top entry is
      // visible on ras_top and ckpt_out even while the stack is empty.
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= entry_d[i];
    end
  end

  assign ras.ras_top  = '{data: top.data, valid: (count_q != '0)};
  assign ras.ckpt_out = '{ptr: ptr_q, count: count_q, data: top.data, rcnt: top.rcnt};

endmodule

// File: tb/tb_ras_ckpt.sv
// Self-checking bench for ras_ckpt: directed vector table, hand-written
// overflow/restore/flush sequences, then random traffic against a model.
module tb_ras_ckpt;
  import ras_ckpt_pkg::*;

  localparam int MAX_RCNT = (1 << RAS_CNT_WIDTH) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ras_ckpt_if ras_if ();

  ras_ckpt dut (
    .clk   (clk),
    .reset (reset),
    .ras   (ras_if.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit    fl, pu, po;
    virt_t d;
    bit    ev;
    virt_t ed;
    int    ep, ec, er;
  } vec_t;

  vec_t vecs[$];

  // Reference model: plain arrays indexed with modulo arithmetic.
  virt_t m_data [RAS_DEPTH];
  int    m_rcnt [RAS_DEPTH];
  int    m_ptr, m_cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic ras_ckpt_t mk_ckpt(input int p, input int c, input virt_t d, input int r);
    ras_ckpt_t k;
    k.ptr   = RAS_PTR_W'(p);
    k.count = (RAS_PTR_W + 1)'(c);
    k.data  = d;
    k.rcnt  = RAS_CNT_WIDTH'(r);
    return k;
  endfunction

  function automatic ras_t mk_top(input virt_t d, input bit v);
    ras_t t;
    t.data  = d;
    t.valid = v;
    return t;
  endfunction

  task automatic idle();
    ras_if.flush        = 1'b0;
    ras_if.push_req     = 1'b0;
    ras_if.pop_req      = 1'b0;
    ras_if.push_data    = '0;
    ras_if.restore_req  = 1'b0;
    ras_if.restore_ckpt = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input bit fl, input bit pu, input bit po, input virt_t d,
                         input bit ev, input virt_t ed, input int ep, input int ec, input int er);
    vec_t v;
    v.fl = fl; v.pu = pu; v.po = po; v.d = d;
    v.ev = ev; v.ed = ed; v.ep = ep; v.ec = ec; v.er = er;
    vecs.push_back(v);
  endtask

  task automatic model_step();
    ras_ckpt_t k;
    k = ras_if.restore_ckpt;
    if (reset || ras_if.flush) begin
      for (int i = 0; i < RAS_DEPTH; i++) begin
        m_data[i] = '0;
        m_rcnt[i] = 0;
      end
      m_ptr = 0;
      m_cnt = 0;
    end else if (ras_if.restore_req) begin
      m_ptr = int'(k.ptr);
      m_cnt = int'(k.count);
      m_data[m_ptr] = k.data;
      m_rcnt[m_ptr] = int'(k.rcnt);
    end else if (ras_if.push_req && ras_if.pop_req) begin
      m_data[m_ptr] = ras_if.push_data;
      m_rcnt[m_ptr] = 0;
      if (m_cnt == 0) m_cnt = 1;
    end else if (ras_if.push_req) begin
      if (m_cnt > 0 && ras_if.push_data == m_data[m_ptr] && m_rcnt[m_ptr] < MAX_RCNT) begin
        m_rcnt[m_ptr]++;
      end else begin
        m_ptr = (m_ptr + 1) % RAS_DEPTH;
        m_data[m_ptr] = ras_if.push_data;
        m_rcnt[m_ptr] = 0;
        if (m_cnt < RAS_DEPTH) m_cnt++;
      end
    end else if (ras_if.pop_req && m_cnt > 0) begin
      if (m_rcnt[m_ptr] > 0) begin
        m_rcnt[m_ptr]--;
      end else begin
        m_ptr = (m_ptr + RAS_DEPTH - 1) % RAS_DEPTH;
        m_cnt--;
      end
    end
  endtask

  initial begin
    ras_ckpt_t cap;
    ras_ckpt_t hist[$];
    int        r;
    virt_t     pool[4];

    // Reset state
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("reset_top", 64'(ras_if.ras_top), 64'(mk_top('0, 1'b0)));
    check("reset_ckpt", 64'(ras_if.ckpt_out), 64'(mk_ckpt(0, 0, '0, 0)));

    // Directed table: fl pu po data | valid data ptr count rcnt
    add_vec(0, 1, 0, 32'h1000, 1, 32'h1000, 1, 1, 0);
    add_vec(0, 1, 0, 32'h2000, 1, 32'h2000, 2, 2, 0);
    add_vec(0, 1, 0, 32'h3000, 1, 32'h3000, 3, 3, 0);
    add_vec(0, 0, 1, 32'h0,    1, 32'h2000, 2, 2, 0);
    add_vec(0, 0, 1, 32'h0,    1, 32'h1000, 1, 1, 0);
    add_vec(0, 0, 1, 32'h0,    0, 32'h0,    0, 0, 0);
    add_vec(0, 0, 1, 32'h0,    0, 32'h0,    0, 0, 0);
    // Recursion folding
    add_vec(0, 1, 0, 32'h4000, 1, 32'h4000, 1, 1, 0);
    add_vec(0, 1, 0, 32'h4000, 1, 32'h4000, 1, 1, 1);
    add_vec(0, 1, 0, 32'h4000, 1, 32'h4000, 1, 1, 2);
    add_vec(0, 1, 0, 32'h4000, 1, 32'h4000, 1, 1, 3);
    add_vec(0, 1, 0, 32'h4000, 1, 32'h4000, 2, 2, 0);
    add_vec(0, 0, 1, 32'h0,    1, 32'h4000, 1, 1, 3);
    add_vec(0, 0, 1, 32'h0,    1, 32'h4000, 1, 1, 2);
    add_vec(0, 0, 1, 32'h0,    1, 32'h4000, 1, 1, 1);
    add_vec(0, 0, 1, 32'h0,    1, 32'h4000, 1, 1, 0);
    add_vec(0, 0, 1, 32'h0,    0, 32'h0,    0, 0, 0);
    add_vec(0, 0, 1, 32'h0,    0, 32'h0,    0, 0, 0);
    // Simultaneous push+pop, empty then folded top
    add_vec(0, 1, 1, 32'h500,  1, 32'h500,  0, 1, 0);
    add_vec(0, 1, 0, 32'h600,  1, 32'h600,  1, 2, 0);
    add_vec(0, 1, 0, 32'h600,  1, 32'h600,  1, 2, 1);
    add_vec(0, 1, 0, 32'h600,  1, 32'h600,  1, 2, 2);
    add_vec(0, 1, 1, 32'h500,  1, 32'h500,  1, 2, 0);
    // Flush with a push on a three-deep stack
    add_vec(0, 1, 0, 32'h700,  1, 32'h700,  2, 3, 0);
    add_vec(1, 1, 0, 32'h800,  0, 32'h0,    0, 0, 0);

    foreach (vecs[i]) begin
      ras_if.flush     = vecs[i].fl;
      ras_if.push_req  = vecs[i].pu;
      ras_if.pop_req   = vecs[i].po;
      ras_if.push_data = vecs[i].d;
      tick();
      check($sformatf("vec%0d_top", i), 64'(ras_if.ras_top), 64'(mk_top(vecs[i].ed, vecs[i].ev)));
      check($sformatf("vec%0d_ckpt", i), 64'(ras_if.ckpt_out),
            64'(mk_ckpt(vecs[i].ep, vecs[i].ec, vecs[i].ed, vecs[i].er)));
    end
    idle();

    // Overflow: 17 distinct pushes, oldest lost
    reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i <= 16; i++) begin
      ras_if.push_req  = 1'b1;
      ras_if.push_data = 32'h100 + virt_t'(i);
      tick();
    end
    idle();
    check("ovf_full", 64'(ras_if.ckpt_out), 64'(mk_ckpt(1, 16, 32'h110, 0)));
    for (int i = 0; i < 16; i++) begin
      check($sformatf("ovf_pop%0d", i), 64'(ras_if.ras_top), 64'(mk_top(32'h110 - virt_t'(i), 1'b1)));
      ras_if.pop_req = 1'b1;
      tick();
    end
    check("ovf_empty_valid", 64'(ras_if.ras_top.valid), 64'(0));
    tick();
    check("ovf_underflow", 64'(ras_if.ckpt_out), 64'(mk_ckpt(1, 0, 32'h110, 0)));
    idle();

    // Restore overrides a same-cycle push
    reset = 1'b1; tick(); reset = 1'b0;
    ras_if.push_req = 1'b1; ras_if.push_data = 32'hA00; tick();
    cap = ras_if.ckpt_out;
    check("rst_capture", 64'(cap), 64'(mk_ckpt(1, 1, 32'hA00, 0)));
    ras_if.push_req = 1'b0; ras_if.pop_req = 1'b1; tick();
    ras_if.pop_req = 1'b0; ras_if.push_req = 1'b1; ras_if.push_data = 32'hB00; tick();
    ras_if.push_data = 32'hC00; tick();
    check("rst_wrongpath", 64'(ras_if.ckpt_out), 64'(mk_ckpt(2, 2, 32'hC00, 0)));
    ras_if.push_data = 32'hD00; ras_if.restore_req = 1'b1; ras_if.restore_ckpt = cap; tick();
    idle();
    check("restore_top", 64'(ras_if.ras_top), 64'(mk_top(32'hA00, 1'b1)));
    check("restore_ckpt", 64'(ras_if.ckpt_out), 64'(mk_ckpt(1, 1, 32'hA00, 0)));

    // Reset beats a same-cycle restore
    ras_if.restore_req = 1'b1; ras_if.restore_ckpt = mk_ckpt(3, 2, 32'hBEEF, 1);
    reset = 1'b1; tick(); reset = 1'b0;
    idle();
    check("reset_vs_restore", 64'(ras_if.ckpt_out), 64'(mk_ckpt(0, 0, '0, 0)));

    // Random traffic against the model
    pool[0] = 32'h10; pool[1] = 32'h20; pool[2] = 32'h30; pool[3] = 32'h40;
    reset = 1'b1; model_step(); tick(); reset = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      idle();
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        ras_if.flush = 1'b1;
      end else if (r < 9 && hist.size() > 0) begin
        ras_if.restore_req  = 1'b1;
        ras_if.restore_ckpt = hist[$urandom_range(0, hist.size() - 1)];
      end
      ras_if.push_req  = ($urandom_range(0, 99) < 55);
      ras_if.pop_req   = ($urandom_range(0, 99) < 45);
      ras_if.push_data = pool[$urandom_range(0, 3)];
      model_step();
      tick();
      check($sformatf("rnd%0d_top", c), 64'(ras_if.ras_top), 64'(mk_top(m_data[m_ptr], m_cnt != 0)));
      check($sformatf("rnd%0d_ckpt", c), 64'(ras_if.ckpt_out),
            64'(mk_ckpt(m_ptr, m_cnt, m_data[m_ptr], m_rcnt[m_ptr])));
      hist.push_back(mk_ckpt(m_ptr, m_cnt, m_data[m_ptr], m_rcnt[m_ptr]));
      if (hist.size() > 16) void'(hist.pop_front());
    end
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
